// File: rtl/subroutine_ctrl_pkg.sv
// subroutine_ctrl_pkg: opcodes, state encoding and stack geometry shared by the call/return sequencer and the PC stack.
package subroutine_ctrl_pkg;
  localparam int ADDR_W = 12;
  localparam int SP_W = 3;
  localparam int DEPTH = 8;
  localparam logic [3:0] OP_JMS = 4'h5;
  localparam logic [3:0] OP_BBL = 4'hC;
  typedef enum logic [2:0] {
    S_IDLE,
    S_JMS_WAIT2,
    S_JMS_EXEC,
    S_BBL_POP,
    S_BBL_LOAD,
    S_FAULT
  } state_e;
endpackage

// File: rtl/subroutine_ctrl.sv
// subroutine_ctrl: JMS/BBL call-return sequencer driving the PC stack, PC and accumulator loads.
// Outputs are decoded from registered state; FAULT is sticky until reset.
module subroutine_ctrl #(
  parameter int ADDR_W = subroutine_ctrl_pkg::ADDR_W,
  parameter int SP_W = subroutine_ctrl_pkg::SP_W,
  parameter int DEPTH = subroutine_ctrl_pkg::DEPTH
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              instValid,
  input  logic [7:0]        instByte,
  input  logic [ADDR_W-1:0] pcRet,
  input  logic              flush,
  input  logic [SP_W-1:0]   stackSp,
  input  logic [ADDR_W-1:0] stackPcOut,
  output logic              stackPush,
  output logic              stackPop,
  output logic [ADDR_W-1:0] stackPcIn,
  output logic              pcLoad,
  output logic [ADDR_W-1:0] pcLoadValue,
  output logic              accLoad,
  output logic [3:0]        accData,
  output logic              busy,
  output logic              fault
);
  import subroutine_ctrl_pkg::*;

  state_e            state_q, state_d;
  logic [3:0]        hi_q, hi_d, acc_q, acc_d;
  logic [ADDR_W-1:0] target_q, target_d, ret_q, ret_d;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q  <= S_IDLE;
      hi_q     <= '0;
      acc_q    <= '0;
      target_q <= '0;
      ret_q    <= '0;
    end else begin
      state_q  <= state_d;
      hi_q     <= hi_d;
      acc_q    <= acc_d;
      target_q <= target_d;
      ret_q    <= ret_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    hi_d     = hi_q;
    acc_d    = acc_q;
    target_d = target_q;
    ret_d    = ret_q;
    case (state_q)
      S_IDLE: begin
        if (instValid && !flush && instByte[7:4] == OP_JMS) begin
          hi_d    = instByte[3:0];
          state_d = S_JMS_WAIT2;
        end else if (instValid && !flush && instByte[7:4] == OP_BBL) begin
          acc_d   = instByte[3:0];
          state_d = (stackSp == '0) ? S_FAULT : S_BBL_POP;
        end
      end
      S_JMS_WAIT2: begin
        if (flush) state_d = S_IDLE;
        else if (instValid) begin
          target_d = ADDR_W'({hi_q, instByte});
          ret_d    = pcRet;
          state_d  = (stackSp == SP_W'(DEPTH - 1)) ? S_FAULT : S_JMS_EXEC;
        end
      end
      S_BBL_POP: state_d = flush ? S_IDLE : S_BBL_LOAD;
      S_FAULT:   state_d = S_FAULT;
      default:   state_d = S_IDLE;
    endcase
  end

  // Pop data arrives from the stack register one cycle after the pop strobe.
  always_comb begin
    stackPush   = state_q == S_JMS_EXEC;
    stackPop    = state_q == S_BBL_POP;
    pcLoad      = state_q == S_JMS_EXEC || state_q == S_BBL_LOAD;
    accLoad     = state_q == S_BBL_LOAD;
    busy        = state_q != S_IDLE;
    fault       = state_q == S_FAULT;
    stackPcIn   = stackPush ? ret_q : '0;
    pcLoadValue = stackPush ? target_q : accLoad ? stackPcOut : '0;
    accData     = accLoad ? acc_q : '0;
  end
endmodule
